// File: rtl/seq_pkg.sv
// Shared types for the program sequencer: instruction layout, kind encodings and FSM states.
package seq_pkg;

    localparam int unsigned INSTR_W = 21;

    localparam int unsigned KIND_MSB = 20;
    localparam int unsigned KIND_LSB = 19;
    localparam int unsigned OP_MSB   = 18;
    localparam int unsigned OP_LSB   = 16;
    localparam int unsigned OPA_MSB  = 15;
    localparam int unsigned OPA_LSB  = 8;
    localparam int unsigned OPB_MSB  = 7;
    localparam int unsigned OPB_LSB  = 0;

    typedef enum logic [1:0] {
        KIND_EXEC = 2'b00,
        KIND_JMP  = 2'b01,
        KIND_JC   = 2'b10,
        KIND_HALT = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StWait,
        StHalted
    } state_e;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] op;
        logic [7:0] opa;
        logic [7:0] opb;
    } instr_t;

    function automatic logic [INSTR_W-1:0] make_instr(kind_e kind, logic [2:0] op,
                                                      logic [7:0] opa, logic [7:0] opb);
        logic [INSTR_W-1:0] w;
        w                   = '0;
        w[KIND_MSB:KIND_LSB] = kind;
        w[OP_MSB:OP_LSB]     = op;
        w[OPA_MSB:OPA_LSB]   = opa;
        w[OPB_MSB:OPB_LSB]   = opb;
        return w;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Issue/result handshake between the sequencer (master) and the execution datapath (slave).
interface program_sequencer_if;

    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       issue_valid;
    logic       result_valid;
    logic [7:0] result_in;
    logic [7:0] carry_in;

    modport master (
        output opcode, a, b, issue_valid,
        input  result_valid, result_in, carry_in
    );

    modport slave (
        input  opcode, a, b, issue_valid,
        output result_valid, result_in, carry_in
    );

endinterface

// File: rtl/program_ram.sv
// Program store: synchronous write, registered read (one cycle latency), no reset.
module program_ram
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_sequencer.sv
// Fetches instructions from program_ram and issues opcode/a/b to the datapath.
// Optional watchdog on the result wait is enabled with SEQ_WATCHDOG_EN.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                prog_we_i,
    input  logic [AW-1:0]       prog_addr_i,
    input  logic [INSTR_W-1:0]  prog_data_i,
    program_sequencer_if.master dp_io,
    output logic                busy_o,
    output logic                done_o,
    output logic [AW-1:0]       pc_o,
    output logic [7:0]          last_result_o,
    output logic [7:0]          last_carry_o,
    output logic                error_o
);

    state_e             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic               issue_valid_q, issue_valid_d;
    logic [7:0]         last_result_q, last_result_d;
    logic [7:0]         last_carry_q, last_carry_d;
    logic [INSTR_W-1:0] ram_rdata;
    instr_t             instr;
    logic [AW-1:0]      target;
    logic               idle_like;
    logic               start_ok;
    logic               wd_expire;

    assign idle_like = (state_q == StIdle) || (state_q == StHalted);
    assign start_ok  = start_i && idle_like;
    assign instr     = instr_t'(ram_rdata);
    assign target    = instr.opb[AW-1:0];

    // pc is read every cycle; the word for pc is therefore valid in DECODE.
    program_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (prog_we_i && idle_like),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (pc_q),
        .rdata_o (ram_rdata)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wd_cnt_q;
    logic            error_q;

    assign wd_expire = (state_q == StWait) && !dp_io.result_valid &&
                       (wd_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state_q == StWait) begin
                wd_cnt_q <= wd_cnt_q + CntW'(1);
            end else begin
                wd_cnt_q <= '0;
            end
            if (start_ok) begin
                error_q <= 1'b0;
            end else if (wd_expire) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wd_expire      = 1'b0;
    assign error_o        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= '0;
            opcode_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            issue_valid_q <= 1'b0;
            last_result_q <= '0;
            last_carry_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            issue_valid_q <= issue_valid_d;
            last_result_q <= last_result_d;
            last_carry_q  <= last_carry_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        a_d           = a_q;
        b_d           = b_q;
        issue_valid_d = issue_valid_q;
        last_result_d = last_result_q;
        last_carry_d  = last_carry_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (start_i) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                unique case (instr.kind)
                    KIND_EXEC: begin
                        opcode_d      = instr.op;
                        a_d           = instr.opa;
                        b_d           = instr.opb;
                        issue_valid_d = 1'b1;
                        state_d       = StWait;
                    end
                    KIND_JMP: begin
                        pc_d    = target;
                        state_d = StFetch;
                    end
                    KIND_JC: begin
                        pc_d    = (last_carry_q != 8'h00) ? target : pc_q + AW'(1);
                        state_d = StFetch;
                    end
                    KIND_HALT: begin
                        state_d = StHalted;
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
            StWait: begin
                if (dp_io.result_valid) begin
                    last_result_d = dp_io.result_in;
                    last_carry_d  = dp_io.carry_in;
                    issue_valid_d = 1'b0;
                    pc_d          = pc_q + AW'(1);
                    state_d       = StFetch;
                end else if (wd_expire) begin
                    issue_valid_d = 1'b0;
                    state_d       = StHalted;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy_o = !idle_like;
        done_o = (state_q == StHalted);
    end

    assign dp_io.opcode      = opcode_q;
    assign dp_io.a           = a_q;
    assign dp_io.b           = b_q;
    assign dp_io.issue_valid = issue_valid_q;
    assign pc_o              = pc_q;
    assign last_result_o     = last_result_q;
    assign last_carry_o      = last_carry_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: instruction-level reference model plus a randomized responder.
module tb_program_sequencer;
    import seq_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               busy;
    logic               done;
    logic [AW-1:0]      pc;
    logic [7:0]         last_result;
    logic [7:0]         last_carry;
    logic               err;

    program_sequencer_if dp ();

    program_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .prog_we_i     (prog_we),
        .prog_addr_i   (prog_addr),
        .prog_data_i   (prog_data),
        .dp_io         (dp),
        .busy_o        (busy),
        .done_o        (done),
        .pc_o          (pc),
        .last_result_o (last_result),
        .last_carry_o  (last_carry),
        .error_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: program contents and the last captured result/carry.
    logic [INSTR_W-1:0] mem_m [DEPTH];
    logic [7:0]         lr_m;
    logic [7:0]         lc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int addr, input logic [INSTR_W-1:0] w);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = w;
        @(negedge clk);
        prog_we   = 1'b0;
        mem_m[addr] = w;
    endtask

    // Start at address 0 and follow the program instruction by instruction.
    // stall < 0 picks a random response delay; poke tries a write and a start while waiting.
    task automatic run_prog(input int max_steps, input int stall, input bit poke,
                            input bit wr0, input logic [INSTR_W-1:0] w0, output bit halted);
        int                 pcm;
        int                 d;
        logic [INSTR_W-1:0] w;
        logic [7:0]         r;
        logic [7:0]         c;
        pcm    = 0;
        halted = 1'b0;
        start  = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = w0;
            mem_m[0]  = w0;
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        for (int s = 0; s < max_steps && !halted; s++) begin
            check("pc_at_fetch", 32'(pc), 32'(pcm));
            check("busy_at_fetch", 32'(busy), 32'd1);
            w = mem_m[pcm];
            repeat (2) @(negedge clk);
            case (w[20:19])
                2'b01: pcm = int'(w[AW-1:0]);
                2'b10: pcm = (lc_m != 8'h00) ? int'(w[AW-1:0]) : (pcm + 1) % DEPTH;
                2'b11: begin
                    check("halt_done_busy", {done, busy}, 32'b10);
                    check("halt_pc", 32'(pc), 32'(pcm));
                    halted = 1'b1;
                end
                default: begin
                    check("issue", {dp.issue_valid, dp.opcode, dp.a, dp.b},
                          {1'b1, w[18:16], w[15:8], w[7:0]});
                    d = (stall >= 0) ? stall : int'($urandom_range(0, 3));
                    for (int i = 0; i < d; i++) begin
                        if (poke && i == 0) begin
                            prog_we   = 1'b1;
                            prog_addr = AW'((pcm + 1) % DEPTH);
                            prog_data = mem_m[(pcm + 1) % DEPTH] ^ 21'h1FFFFF;
                            start     = 1'b1;
                        end
                        @(negedge clk);
                        prog_we = 1'b0;
                        start   = 1'b0;
                        check("hold_in_wait", {dp.issue_valid, dp.opcode, dp.a, dp.b, busy},
                              {1'b1, w[18:16], w[15:8], w[7:0], 1'b1});
                    end
                    // Responder: op 0 adds, op 1 returns b as carry, others random.
                    r = (w[18:16] == 3'd0) ? w[15:8] + w[7:0] : 8'($urandom);
                    c = (w[18:16] == 3'd1) ? w[7:0] :
                        ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                    dp.result_valid = 1'b1;
                    dp.result_in    = r;
                    dp.carry_in     = c;
                    @(negedge clk);
                    dp.result_valid = 1'b0;
                    dp.result_in    = 8'($urandom);
                    dp.carry_in     = 8'($urandom);
                    lr_m = r;
                    lc_m = c;
                    check("capture", {last_result, last_carry}, {lr_m, lc_m});
                    check("issue_dropped_ops_kept", {dp.issue_valid, dp.opcode, dp.a, dp.b},
                          {1'b0, w[18:16], w[15:8], w[7:0]});
                    pcm = (pcm + 1) % DEPTH;
                end
            endcase
        end
    endtask

    bit                 halted;
    int                 rnd;
    kind_e              kind;
    logic [INSTR_W-1:0] zero_w;

    initial begin
        zero_w          = '0;
        lr_m            = 8'h00;
        lc_m            = 8'h00;
        rst_n           = 1'b0;
        start           = 1'b0;
        prog_we         = 1'b0;
        prog_addr       = '0;
        prog_data       = '0;
        dp.result_valid = 1'b0;
        dp.result_in    = '0;
        dp.carry_in     = '0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start           = 1'($urandom);
            prog_we         = 1'($urandom);
            prog_addr       = AW'($urandom);
            prog_data       = INSTR_W'($urandom);
            dp.result_valid = 1'($urandom);
            dp.result_in    = 8'($urandom);
            dp.carry_in     = 8'($urandom);
            check("reset_outputs", {busy, done, pc, last_result, last_carry, err},
                  32'd0);
            check("reset_issue", {dp.issue_valid, dp.opcode, dp.a, dp.b}, 32'd0);
        end
        start           = 1'b0;
        prog_we         = 1'b0;
        dp.result_valid = 1'b0;
        rst_n           = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", {busy, done, pc}, 32'd0);

        // result_valid while idle is ignored.
        dp.result_valid = 1'b1;
        dp.result_in    = 8'hAA;
        dp.carry_in     = 8'h55;
        @(negedge clk);
        dp.result_valid = 1'b0;
        @(negedge clk);
        check("idle_rv_ignored", {busy, last_result, last_carry}, 32'd0);

        // Single EXEC then HALT.
        for (int ad = 0; ad < DEPTH; ad++) prog(ad, make_instr(KIND_HALT, 3'd0, 8'h00, 8'h00));
        prog(0, make_instr(KIND_EXEC, 3'd0, 8'h0F, 8'h01));
        run_prog(10, 1, 1'b0, 1'b0, zero_w, halted);
        check("single_halted", 32'(halted), 32'd1);
        check("single_result", {done, pc, last_result}, {1'b1, 4'd1, 8'h10});

        // JC taken on nonzero carry; upper target bits ignored.
        prog(0, make_instr(KIND_EXEC, 3'd1, 8'h22, 8'h01));
        prog(1, make_instr(KIND_JC, 3'd0, 8'h00, 8'hF5));
        run_prog(10, 0, 1'b0, 1'b0, zero_w, halted);
        check("jc_taken", {32'(halted), 32'(pc)}, {32'd1, 32'd5});

        // Start with a same-cycle write to address 0: carry 0 falls through to 2.
        run_prog(10, 0, 1'b0, 1'b1, make_instr(KIND_EXEC, 3'd1, 8'h22, 8'h00), halted);
        check("jc_not_taken", {32'(halted), 32'(pc)}, {32'd1, 32'd2});

        // JMP from the last address.
        prog(0, make_instr(KIND_JMP, 3'd0, 8'h00, 8'h0F));
        prog(15, make_instr(KIND_JMP, 3'd0, 8'h00, 8'h03));
        prog(3, make_instr(KIND_HALT, 3'd0, 8'h00, 8'h00));
        run_prog(10, -1, 1'b0, 1'b0, zero_w, halted);
        check("jmp_last", {32'(halted), 32'(pc)}, {32'd1, 32'd3});

        // EXEC at DEPTH-1 wraps pc to 0; carry then redirects the JC at 0.
        prog(0, make_instr(KIND_JC, 3'd0, 8'h00, 8'h05));
        prog(1, make_instr(KIND_JMP, 3'd0, 8'h00, 8'h0F));
        prog(15, make_instr(KIND_EXEC, 3'd1, 8'h33, 8'h01));
        prog(5, make_instr(KIND_HALT, 3'd0, 8'h00, 8'h00));
        run_prog(12, -1, 1'b0, 1'b0, zero_w, halted);
        check("wrap_halt", {32'(halted), 32'(pc)}, {32'd1, 32'd5});

        // Long stall with an ignored write and start during WAIT.
        prog(0, make_instr(KIND_EXEC, 3'd2, 8'($urandom), 8'($urandom)));
        prog(1, make_instr(KIND_EXEC, 3'd3, 8'($urandom), 8'($urandom)));
        prog(2, make_instr(KIND_HALT, 3'd0, 8'h00, 8'h00));
        run_prog(10, 10, 1'b1, 1'b0, zero_w, halted);
        check("stall_halt", {32'(halted), 32'(pc)}, {32'd1, 32'd2});

`ifdef SEQ_WATCHDOG_EN
        // No response: error after 8 WAIT cycles, cleared by the next start.
        prog(0, make_instr(KIND_EXEC, 3'd4, 8'h12, 8'h34));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("wd_waiting", {dp.issue_valid, busy, err}, 32'b110);
        repeat (7) @(negedge clk);
        check("wd_before_limit", {dp.issue_valid, busy, err}, 32'b110);
        @(negedge clk);
        check("wd_fault", {err, done, dp.issue_valid}, 32'b110);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wd_cleared", {err, busy}, 32'b01);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lr_m  = 8'h00;
        lc_m  = 8'h00;
`endif

        // Random programs; a run that does not halt is cut short by reset.
        for (int t = 0; t < 6; t++) begin
            for (int ad = 0; ad < DEPTH; ad++) begin
                rnd  = int'($urandom_range(0, 99));
                kind = (rnd < 50) ? KIND_EXEC : (rnd < 65) ? KIND_JMP :
                       (rnd < 85) ? KIND_JC : KIND_HALT;
                prog(ad, make_instr(kind, 3'($urandom), 8'($urandom), 8'($urandom)));
            end
            run_prog(30, -1, 1'b0, 1'b0, zero_w, halted);
            if (!halted) begin
                rst_n = 1'b0;
                #1;
                check("midrun_reset", {busy, done, pc, dp.issue_valid, last_result, last_carry},
                      32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                lr_m  = 8'h00;
                lc_m  = 8'h00;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
